// File: rtl/led_pkg.sv
// Shared constants and FSM encoding for the LED breathing controller.
package led_pkg;

  localparam int CLK_HZ = 12_000_000;
  // One brightness step per CLK_HZ/256 cycles gives roughly a 1 s ramp over 256 levels.
  localparam int STEP_DIV_DEFAULT = CLK_HZ / 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and comparator; led is registered, one cycle behind duty.
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led
);

  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                led_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg <= '0;
      led_reg     <= 1'b0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
      led_reg     <= (pwm_cnt_reg < duty);
    end
  end

  assign led = led_reg;

endmodule

// File: rtl/led_breathe.sv
// Breathing LED: ramps PWM brightness up, holds, ramps down while en is requested.
// Optional square-law brightness mapping when LED_BREATHE_GAMMA_EN is defined.
module led_breathe
  import led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = STEP_DIV_DEFAULT,
  parameter int HOLD_STEPS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic                busy,
  output logic [PWM_BITS-1:0] level
);

  localparam int PW = cnt_width(STEP_DIV);
  localparam int HW = cnt_width(HOLD_STEPS);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

  state_t              state_reg, state_next;
  logic [PWM_BITS-1:0] level_reg, level_next;
  logic [PW-1:0]       presc_reg, presc_next;
  logic [HW-1:0]       hold_reg, hold_next;
  logic                busy_reg;
  logic                tick;
  logic [PWM_BITS-1:0] duty;

  assign tick = (presc_reg == PW'(STEP_DIV - 1));

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    hold_next  = hold_reg;
    presc_next = tick ? '0 : presc_reg + PW'(1);
    case (state_reg)
      IDLE: begin
        // Prescaler parked at zero so the first step lands STEP_DIV cycles after leaving IDLE.
        level_next = '0;
        presc_next = '0;
        if (en) state_next = UP;
      end
      UP: begin
        if (!en) begin
          state_next = DOWN;
        end else if (tick) begin
          if (level_reg == LEVEL_MAX) begin
            state_next = HOLD;
            hold_next  = '0;
          end else begin
            level_next = level_reg + PWM_BITS'(1);
          end
        end
      end
      HOLD: begin
        if (!en) begin
          state_next = DOWN;
        end else if (tick) begin
          if (hold_reg == HW'(HOLD_STEPS - 1)) state_next = DOWN;
          else hold_next = hold_reg + HW'(1);
        end
      end
      DOWN: begin
        // Down-ramp always completes before en is looked at again.
        if (tick) begin
          if (level_reg == '0) state_next = en ? UP : IDLE;
          else level_next = level_reg - PWM_BITS'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      level_reg <= '0;
      presc_reg <= '0;
      hold_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      presc_reg <= presc_next;
      hold_reg  <= hold_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq = {{PWM_BITS{1'b0}}, level_reg} * {{PWM_BITS{1'b0}}, level_reg};
  assign duty     = PWM_BITS'(level_sq >> PWM_BITS);
`else
  assign duty = level_reg;
`endif

  led_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk (clk),
    .rst (rst),
    .duty(duty),
    .led (led)
  );

  assign busy  = busy_reg;
  assign level = level_reg;

endmodule

// File: doc/led_breathe.md
Name: led_breathe

Overview:
- Downstream consumer of the single-bit LED request produced by the set-bit stage on the icezum board.
- Does not drive the LED statically. Turns a request level into a "breathing" LED: PWM brightness ramps up, holds, then ramps down.
- Sits between the logic that asserts the LED bit and the physical LED pin.
- Runs from the 12 MHz board clock.

Parameters:
- PWM_BITS, 8: width of the brightness level and PWM counter. PWM period is 2^PWM_BITS clk.
- STEP_DIV, 46875: clk cycles per brightness step tick. Default gives about 1 s full ramp at 12 MHz.
- HOLD_STEPS, 64: step ticks spent at full brightness before ramping down.

Ports:
- clk     in   1         board clock, single clock domain
- rst     in   1         synchronous reset, active-high
- en      in   1         LED request bit from the upstream set-bit stage
- led     out  1         PWM drive to LED pin, registered
- busy    out  1         high whenever the FSM is not in IDLE
- level   out  PWM_BITS  current brightness level, registered

Behaviour:
- Reset values (any clk edge with rst=1): state=IDLE, level=0, led=0, busy=0, PWM counter=0, prescaler=0, hold counter=0. Reset has priority over every other event.
- Reset asserted mid-operation: all registers return to these values at the next edge. Restarting requires en=1 after rst falls.
- PWM counter:
  - Free-running, increments every clk, wraps from 2^PWM_BITS-1 to 0.
  - led <= (pwm_cnt < duty). This is one cycle of latency from duty to pin.
  - duty=0 gives led constantly 0. Maximum duty gives led high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- Prescaler:
  - Counts 0..STEP_DIV-1. tick=1 for one cycle when the count equals STEP_DIV-1, then wraps to 0.
  - Cleared on the IDLE->UP transition so the first tick arrives exactly STEP_DIV cycles after leaving IDLE.
- FSM:
  - IDLE: level=0. When en=1, go to UP and clear the prescaler.
  - UP:
    - en=0: go to DOWN on the next edge; level is unchanged and tick is ignored (en has priority).
    - Otherwise on tick: if level==MAX, go to HOLD and clear the hold counter; else level+1.
  - HOLD:
    - en=0: go to DOWN immediately.
    - On tick: if hold_cnt==HOLD_STEPS-1, go to DOWN; else hold_cnt+1.
  - DOWN:
    - On tick: if level==0, go to UP when en=1, otherwise IDLE; else level-1.
    - en rising during DOWN does not reverse the ramp; the down-ramp completes first.
- level saturates by construction: it never wraps, and there is no arithmetic overflow.
- busy = (state != IDLE), registered alongside state.
- When en is held constantly 1 (the set-bit case), the output breathes continuously: UP, HOLD, DOWN, UP, ...

Optional Feature:
- Macro LED_BREATHE_GAMMA_EN.
  - Defined: duty = (level*level) >> PWM_BITS. This is a perceptual square-law; the multiply is 2*PWM_BITS wide and the upper half is used.
  - Undefined: duty = level (linear).
- The level port always shows the linear level. led latency is identical in both builds.

Decomposition:
- Shared package/include led_pkg:
  - FSM state encoding localparams: IDLE=2'd0, UP=2'd1, HOLD=2'd2, DOWN=2'd3.
  - Default STEP_DIV derived from the board clock constant CLK_HZ=12_000_000.
- One natural sub-module, led_pwm_gen: PWM counter plus comparator, parameter PWM_BITS, ports clk, rst, duty, led. The FSM, prescaler and gamma mapping stay in led_breathe.

Test Plan (PWM_BITS=4, STEP_DIV=4, HOLD_STEPS=2 unless stated):
- Reset: rst=1 for 3 cycles with en=1 -> led=0, busy=0, level=0 throughout. First tick arrives 4 cycles after the IDLE->UP transition.
- Constant en=1:
  - level increments every 4 clk and reaches 15 after 60 cycles in UP.
  - HOLD is entered on the next tick and lasts 8 clk.
  - level then steps down to 0 over 60 cycles, goes UP again, and busy never drops.
- Duty, linear build: level held at 8 -> led high exactly 8 of every 16 cycles. Level 0 -> led never high. Level 15 -> high 15 of 16.
- en dropped in UP at level=5 -> DOWN on the next edge, level 4,3,...,0 on successive ticks, then IDLE with busy=0. Re-assert en -> UP.
- rst pulsed 1 cycle during HOLD -> next cycle state=IDLE, level=0, led=0. With en=1 the ramp restarts from 0.
- LED_BREATHE_GAMMA_EN defined, level=8 -> duty=4, led high 4 of 16 cycles. level=15 -> duty=14.
